// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and constants for the stopwatch BCD counter.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPED  = 2'd2,
        OVERFLOW = 2'd3
    } sw_state_e;

    localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_bcd_counter_if.sv
// Control and display bundle between the stopwatch and its user (display driver / controls).
interface stopwatch_bcd_counter_if;

    logic                start_i;
    logic                stop_i;
    logic                clear_i;
    logic                running_o;
    logic                overflow_o;
    logic                digit0_en_o;
    logic                digit1_en_o;
    logic                digit2_en_o;
    logic                digit3_en_o;
    stopwatch_pkg::bcd_t digit0_o;
    stopwatch_pkg::bcd_t digit1_o;
    stopwatch_pkg::bcd_t digit2_o;
    stopwatch_pkg::bcd_t digit3_o;

    modport master (
        output start_i, stop_i, clear_i,
        input  running_o, overflow_o,
        input  digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        input  digit0_o, digit1_o, digit2_o, digit3_o
    );

    modport slave (
        input  start_i, stop_i, clear_i,
        output running_o, overflow_o,
        output digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        output digit0_o, digit1_o, digit2_o, digit3_o
    );

endinterface

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// Single BCD digit 0..9 with synchronous clear and ripple carry out.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic clk_1k_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t digit_q;

    // Digit register: clear wins over increment, 9 wraps to 0.
    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else if (clr_i) begin
            digit_q <= '0;
        end else if (inc_i) begin
            digit_q <= (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = inc_i && (digit_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// SS.CC stopwatch: prescaled BCD count, start/stop/clear FSM, blanking and overflow blink.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned BLINK_DIV = 250,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                    clk_1k_i,
    input  logic                    rst_i,
    stopwatch_bcd_counter_if.slave  bus
);

    localparam logic [9:0] TICK_LAST  = 10'(TICK_DIV - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_DIV - 1);

    sw_state_e  state_q, state_d;
    logic [9:0] presc_q, presc_d;
    logic [9:0] blink_cnt_q, blink_cnt_d;
    logic       blink_ph_q, blink_ph_d;

    bcd_t       digit [4];
    logic [3:0] inc;
    logic [3:0] carry;
    logic       tick;
    logic       clr_digits;
    logic       all_nine;

    assign all_nine = (digit[0] == BCD_MAX) && (digit[1] == BCD_MAX) &&
                      (digit[2] == BCD_MAX) && (digit[3] == BCD_MAX);

    // In saturating mode the count must hold at 99.99, so the tick is not passed on.
    assign inc[0]   = tick && !((SATURATE != 0) && all_nine);
    assign inc[3:1] = carry[2:0];

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_1k_i (clk_1k_i),
            .rst_i    (rst_i),
            .clr_i    (clr_digits),
            .inc_i    (inc[i]),
            .digit_o  (digit[i]),
            .carry_o  (carry[i])
        );
    end

    // The top carry only ever fires on a 99.99 -> 00.00 rollover in wrap mode.
    top_carry_only_wraps : assert property (
        @(posedge clk_1k_i) disable iff (rst_i) carry[3] |-> (SATURATE == 0)
    );

    // State, prescaler and blink registers.
    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    // Next-state: clear beats stop beats start; lower requests are dropped.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        tick        = 1'b0;
        clr_digits  = 1'b0;
        if (bus.clear_i) begin
            state_d     = IDLE;
            presc_d     = '0;
            blink_cnt_d = '0;
            blink_ph_d  = 1'b1;
            clr_digits  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE, STOPPED: begin
                    if (!bus.stop_i && bus.start_i) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (bus.stop_i) begin
                        state_d = STOPPED;
                    end else if (presc_q == TICK_LAST) begin
                        presc_d = '0;
                        tick    = 1'b1;
                        if ((SATURATE != 0) && all_nine) begin
                            state_d     = OVERFLOW;
                            blink_cnt_d = '0;
                            blink_ph_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 10'd1;
                    end
                end
                OVERFLOW: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_ph_d  = !blink_ph_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 10'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.running_o   = (state_q == RUN);
        bus.overflow_o  = (state_q == OVERFLOW);
        bus.digit0_en_o = 1'b1;
        bus.digit1_en_o = 1'b1;
        bus.digit2_en_o = 1'b1;
        bus.digit3_en_o = (digit[3] != 4'd0);
        if (state_q == OVERFLOW) begin
            bus.digit0_en_o = blink_ph_q;
            bus.digit1_en_o = blink_ph_q;
            bus.digit2_en_o = blink_ph_q;
            bus.digit3_en_o = blink_ph_q;
        end
    end

    assign bus.digit0_o = digit[0];
    assign bus.digit1_o = digit[1];
    assign bus.digit2_o = digit[2];
    assign bus.digit3_o = digit[3];

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench: saturating and wrapping instances with TICK_DIV=2, BLINK_DIV=4.
module tb_stopwatch_bcd_counter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    stopwatch_bcd_counter_if bs ();
    stopwatch_bcd_counter_if bw ();

    stopwatch_bcd_counter #(.TICK_DIV(2), .BLINK_DIV(4), .SATURATE(1)) u_sat (
        .clk_1k_i (clk),
        .rst_i    (rst),
        .bus      (bs.slave)
    );

    stopwatch_bcd_counter #(.TICK_DIV(2), .BLINK_DIV(4), .SATURATE(0)) u_wrap (
        .clk_1k_i (clk),
        .rst_i    (rst),
        .bus      (bw.slave)
    );

    logic [15:0] s_dig, w_dig;
    logic [3:0]  s_en, w_en;
    assign s_dig = {bs.digit3_o, bs.digit2_o, bs.digit1_o, bs.digit0_o};
    assign w_dig = {bw.digit3_o, bw.digit2_o, bw.digit1_o, bw.digit0_o};
    assign s_en  = {bs.digit3_en_o, bs.digit2_en_o, bs.digit1_en_o, bs.digit0_en_o};
    assign w_en  = {bw.digit3_en_o, bw.digit2_en_o, bw.digit1_en_o, bw.digit0_en_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_s(input logic st, input logic sp, input logic cl);
        bs.start_i = st; bs.stop_i = sp; bs.clear_i = cl;
        step();
        bs.start_i = 1'b0; bs.stop_i = 1'b0; bs.clear_i = 1'b0;
    endtask

    task automatic pulse_w(input logic st, input logic sp, input logic cl);
        bw.start_i = st; bw.stop_i = sp; bw.clear_i = cl;
        step();
        bw.start_i = 1'b0; bw.stop_i = 1'b0; bw.clear_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (s_dig !== 16'h0000 || s_en !== 4'b0111 || bs.running_o !== 1'b0 ||
            bs.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got dig=%h en=%b run=%b ovf=%b want 0000 0111 0 0",
                     s_dig, s_en, bs.running_o, bs.overflow_o);
        end
        checks++;
        if (w_dig !== 16'h0000 || w_en !== 4'b0111) begin
            errors++;
            $display("FAIL reset_init_wrap got dig=%h en=%b want 0000 0111", w_dig, w_en);
        end
        step();
        rst = 1'b0;
        pulse_s(1'b1, 1'b0, 1'b0);
        cycles(6);
        checks++;
        if (s_dig !== 16'h0003 || bs.running_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_count got dig=%h run=%b want 0003 1", s_dig, bs.running_o);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (s_dig !== 16'h0000 || s_en !== 4'b0111 || bs.running_o !== 1'b0 ||
            bs.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got dig=%h en=%b run=%b ovf=%b want 0000 0111 0 0",
                     s_dig, s_en, bs.running_o, bs.overflow_o);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_start_count();
        pulse_s(1'b1, 1'b0, 1'b0);
        checks++;
        if (bs.running_o !== 1'b1 || s_dig !== 16'h0000) begin
            errors++;
            $display("FAIL start_run got run=%b dig=%h want 1 0000", bs.running_o, s_dig);
        end
        cycles(2);
        checks++;
        if (s_dig !== 16'h0001) begin
            errors++;
            $display("FAIL first_tick got %h want 0001", s_dig);
        end
        cycles(8);
        checks++;
        if (s_dig !== 16'h0005) begin
            errors++;
            $display("FAIL count_5 got %h want 0005", s_dig);
        end
        cycles(8);
        checks++;
        if (s_dig !== 16'h0009) begin
            errors++;
            $display("FAIL count_9 got %h want 0009", s_dig);
        end
        cycles(2);
        checks++;
        if (s_dig !== 16'h0010 || s_en !== 4'b0111) begin
            errors++;
            $display("FAIL carry_10 got dig=%h en=%b want 0010 0111", s_dig, s_en);
        end
    endtask

    task automatic test_stop_resume();
        cycles(54);
        checks++;
        if (s_dig !== 16'h0037) begin
            errors++;
            $display("FAIL reach_37 got %h want 0037", s_dig);
        end
        pulse_s(1'b0, 1'b1, 1'b0);
        checks++;
        if (bs.running_o !== 1'b0 || s_dig !== 16'h0037) begin
            errors++;
            $display("FAIL stop got run=%b dig=%h want 0 0037", bs.running_o, s_dig);
        end
        cycles(20);
        checks++;
        if (s_dig !== 16'h0037 || bs.running_o !== 1'b0) begin
            errors++;
            $display("FAIL frozen got run=%b dig=%h want 0 0037", bs.running_o, s_dig);
        end
        pulse_s(1'b1, 1'b0, 1'b0);
        checks++;
        if (bs.running_o !== 1'b1 || s_dig !== 16'h0037) begin
            errors++;
            $display("FAIL resume got run=%b dig=%h want 1 0037", bs.running_o, s_dig);
        end
        cycles(1);
        checks++;
        if (s_dig !== 16'h0037) begin
            errors++;
            $display("FAIL resume_wait got %h want 0037", s_dig);
        end
        cycles(1);
        checks++;
        if (s_dig !== 16'h0038) begin
            errors++;
            $display("FAIL resume_tick got %h want 0038", s_dig);
        end
    endtask

    task automatic test_simultaneous();
        cycles(2392);
        checks++;
        if (s_dig !== 16'h1234 || s_en !== 4'b1111) begin
            errors++;
            $display("FAIL reach_1234 got dig=%h en=%b want 1234 1111", s_dig, s_en);
        end
        pulse_s(1'b1, 1'b1, 1'b1);
        checks++;
        if (s_dig !== 16'h0000 || s_en !== 4'b0111 || bs.running_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_all got dig=%h en=%b run=%b want 0000 0111 0",
                     s_dig, s_en, bs.running_o);
        end
        pulse_s(1'b1, 1'b1, 1'b0);
        checks++;
        if (bs.running_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_stop got run=%b want 0", bs.running_o);
        end
        cycles(4);
        checks++;
        if (s_dig !== 16'h0000 || bs.running_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got dig=%h run=%b want 0000 0", s_dig, bs.running_o);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_en;
        pulse_s(1'b1, 1'b0, 1'b0);
        cycles(19998);
        checks++;
        if (s_dig !== 16'h9999 || bs.running_o !== 1'b1 || bs.overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reach_9999 got dig=%h run=%b ovf=%b want 9999 1 0",
                     s_dig, bs.running_o, bs.overflow_o);
        end
        cycles(2);
        checks++;
        if (s_dig !== 16'h9999 || bs.running_o !== 1'b0 || bs.overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL saturate got dig=%h run=%b ovf=%b want 9999 0 1",
                     s_dig, bs.running_o, bs.overflow_o);
        end
        for (int i = 0; i < 12; i++) begin
            exp_en = (((i / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
            checks++;
            if (s_en !== exp_en) begin
                errors++;
                $display("FAIL blink_%0d got %b want %b", i, s_en, exp_en);
            end
            step();
        end
        pulse_s(1'b1, 1'b0, 1'b0);
        pulse_s(1'b0, 1'b1, 1'b0);
        checks++;
        if (bs.overflow_o !== 1'b1 || bs.running_o !== 1'b0 || s_dig !== 16'h9999) begin
            errors++;
            $display("FAIL ovf_ignore got ovf=%b run=%b dig=%h want 1 0 9999",
                     bs.overflow_o, bs.running_o, s_dig);
        end
        pulse_s(1'b0, 1'b0, 1'b1);
        checks++;
        if (s_dig !== 16'h0000 || bs.overflow_o !== 1'b0 || bs.running_o !== 1'b0 ||
            s_en !== 4'b0111) begin
            errors++;
            $display("FAIL ovf_clear got dig=%h ovf=%b run=%b en=%b want 0000 0 0 0111",
                     s_dig, bs.overflow_o, bs.running_o, s_en);
        end
    endtask

    task automatic test_wrap();
        pulse_w(1'b1, 1'b0, 1'b0);
        cycles(19998);
        checks++;
        if (w_dig !== 16'h9999 || bw.running_o !== 1'b1 || w_en !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_9999 got dig=%h run=%b en=%b want 9999 1 1111",
                     w_dig, bw.running_o, w_en);
        end
        cycles(2);
        checks++;
        if (w_dig !== 16'h0000 || bw.running_o !== 1'b1 || bw.overflow_o !== 1'b0 ||
            w_en !== 4'b0111) begin
            errors++;
            $display("FAIL wrap_0000 got dig=%h run=%b ovf=%b en=%b want 0000 1 0 0111",
                     w_dig, bw.running_o, bw.overflow_o, w_en);
        end
        cycles(1998);
        checks++;
        if (w_dig !== 16'h0999 || w_en !== 4'b0111) begin
            errors++;
            $display("FAIL wrap_0999 got dig=%h en=%b want 0999 0111", w_dig, w_en);
        end
        cycles(2);
        checks++;
        if (w_dig !== 16'h1000 || w_en !== 4'b1111) begin
            errors++;
            $display("FAIL wrap_1000 got dig=%h en=%b want 1000 1111", w_dig, w_en);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bs.start_i = 1'b0; bs.stop_i = 1'b0; bs.clear_i = 1'b0;
        bw.start_i = 1'b0; bw.stop_i = 1'b0; bw.clear_i = 1'b0;
        test_reset();
        test_start_count();
        test_stop_resume();
        test_simultaneous();
        test_saturate();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Timekeeping stage that feeds the Basys3 4-digit 7-segment driver in the stop_it design.
- Counts elapsed time as four BCD digits in SS.CC format, centisecond resolution, 00.00 to 99.99.
- Runs on the 1 kHz system clock with a prescaler.
- Drives per-digit values and enables directly into the driver: digit3 is tens of seconds, digit0 is hundredths.
- Handles start/stop/clear control, leading-zero blanking and an overflow blink.

Parameters:
- TICK_DIV, 10: clk_1k_i cycles per count increment (10 gives 100 Hz). Legal range 1..1023.
- BLINK_DIV, 250: clk_1k_i cycles per half-period of the overflow blink. Legal range 1..1023.
- SATURATE, 1: 1 = hold at 99.99 and enter OVERFLOW; 0 = wrap to 00.00 and keep running.

Ports:
- clk_1k_i  input  1  1 kHz system clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  synchronous one-cycle start/resume request
- stop_i  input  1  synchronous one-cycle stop request
- clear_i  input  1  synchronous one-cycle clear request
- running_o  output  1  high while in RUN
- overflow_o  output  1  high while in OVERFLOW
- digit0_en_o / digit1_en_o / digit2_en_o / digit3_en_o  output  1 each  digit enables, active-high
- digit0_o / digit1_o / digit2_o / digit3_o  output  4 each  BCD digit values, 0..9 only

Behaviour:
- **Clock and reset:** one clock (clk_1k_i). Reset rst_i is asynchronous and active-high.
- **Reset values:**
  - state=IDLE, all digits=0, prescaler=0, blink counter=0, blink phase=1.
  - running_o=0, overflow_o=0.
  - Enables: digit3_en_o=0; digit2/1/0_en_o=1, so the display reads " 0.00".
- **States:** IDLE, RUN, STOPPED, OVERFLOW. Encoded as an enum. The state register is updated on the rising edge of clk_1k_i.
- **Command priority in the same cycle:** clear_i > stop_i > start_i. Lower-priority requests in the same cycle are dropped.
- **Transitions:**
  - Any state + clear_i -> IDLE. Digits=0, prescaler=0, blink cleared.
  - IDLE + start_i -> RUN, prescaler=0.
  - IDLE + stop_i -> ignored.
  - RUN + stop_i -> STOPPED. Digits and prescaler frozen.
  - RUN + start_i -> ignored.
  - STOPPED + start_i -> RUN, prescaler reset to 0. Digits retained.
  - OVERFLOW ignores start_i and stop_i. Only clear_i or reset exits it.
- **Prescaler (RUN only):**
  - Increments each cycle.
  - When prescaler==TICK_DIV-1: prescaler<=0 and the BCD count increments in that same edge.
  - If start is accepted at edge N, the first increment is visible after edge N+TICK_DIV.
- **BCD increment:**
  - digit0 0..9 carries into digit1, then digit2, then digit3. Every digit wraps 9->0.
  - Values above 9 are never produced.
- **At 99.99 with a tick:**
  - SATURATE=1: digits hold 9999, state -> OVERFLOW in that edge, running_o drops.
  - SATURATE=0: digits -> 0000, remain in RUN.
- **Leading-zero blanking** (all states except OVERFLOW):
  - digit3_en_o = (digit3 != 0).
  - digit2/1/0 enables are always 1.
- **OVERFLOW blink:**
  - The blink counter counts 0..BLINK_DIV-1; at terminal count the blink phase toggles.
  - All four enables equal the blink phase. Phase starts at 1 on entry, so all digits are lit for BLINK_DIV cycles, then dark for BLINK_DIV cycles.
- **Output timing:**
  - Digit values come straight from registers, with no combinational path from inputs.
  - Enables, running_o and overflow_o are decoded from registered state only.
- **Reset mid-count:** asynchronous assertion forces all reset values immediately, regardless of the clock.

Decomposition:
- **Package stopwatch_pkg:**
  - typedef bcd_t (logic [3:0]).
  - typedef enum sw_state_e {IDLE, RUN, STOPPED, OVERFLOW}.
  - localparam BCD_MAX = 4'd9.
- **Sub-module bcd_digit:**
  - Ports: clk_1k_i, rst_i, clr_i, inc_i, digit_o, carry_o.
  - carry_o = inc_i && digit==9, combinational.
  - Instantiated 4x and chained carry_o -> inc_i.

Test Plan (TICK_DIV=2, BLINK_DIV=4 unless stated):
1. **Reset:** assert rst_i mid-cycle -> outputs go to reset values immediately: digits 0000, en={0,1,1,1}, running_o=0.
2. **Start and count:** pulse start_i at edge N -> running_o=1 after edge N; digit0=1 after edge N+2; digit0=5 after edge N+10. Then hold count at 00.09 plus one tick -> 00.10 (carry).
3. **Stop/resume:** stop at 00.37 for 20 cycles -> digits frozen at 0,0,3,7. Then start -> 00.38 exactly 2 cycles later.
4. **Simultaneous commands:** clear_i+stop_i+start_i together in RUN at 12.34 -> IDLE, 00.00, digit3_en_o=0, running_o=0. In IDLE, start_i+stop_i together -> stays IDLE.
5. **Saturating overflow:** preload to 99.99, one tick -> digits 9999, overflow_o=1, enables 1 for 4 cycles then 0 for 4 cycles, repeating. start_i is ignored. clear_i -> 00.00, IDLE.
6. **Wrap mode** (SATURATE=0): at 99.99, one tick -> 00.00, running_o stays 1, digit3_en_o drops to 0. The 10.00 boundary raises digit3_en_o.
